// File: rtl/fifo_arb_ctrl.sv
// fifo_arb_ctrl: two-producer, one-consumer FIFO controller.
// Producers are arbitrated round-robin with zero-cycle grant latency.
// Pointer and occupancy state updates on the falling edge of clk.
// Optional almost_full/almost_empty flags are built when FIFO_ARB_ALMOST_EN is defined.
module fifo_arb_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
`ifdef FIFO_ARB_ALMOST_EN
  ,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              rd_req,
  output logic              gnt0,
  output logic              gnt1,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
`ifdef FIFO_ARB_ALMOST_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Priority holder for simultaneous requests: 0 = producer 0, 1 = producer 1
  logic prio;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Grant logic: nothing while full or in reset, otherwise the sole requester
  // or, on contention, whichever producer currently holds priority
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !full) begin
      if (req0 && (!req1 || !prio)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign wr_en  = gnt0 | gnt1;
  assign wr_sel = gnt1;
  assign rd_en  = !reset && rd_req && !empty;

  // Pointer, occupancy and priority state; async reset returns to an empty FIFO
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      wr_addr <= '0;
      rd_addr <= '0;
      count   <= '0;
      prio    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
      end
      if (rd_en) begin
        rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (gnt0) begin
        prio <= 1'b1;
      end else if (gnt1) begin
        prio <= 1'b0;
      end
    end
  end

`ifdef FIFO_ARB_ALMOST_EN
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));
`else
  // Threshold flags are not part of this build
`endif

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// tb_fifo_arb_ctrl: directed, table-driven bench for fifo_arb_ctrl.
// Two instances share stimulus: DEPTH=8 (main) and DEPTH=5 (pointer wrap).
// Covers almost_full/almost_empty as well when FIFO_ARB_ALMOST_EN is defined.
module tb_fifo_arb_ctrl;

  logic clk, reset, req0, req1, rd_req;

  logic       gnt0, gnt1, wr_en, wr_sel, rd_en, full, empty;
  logic [2:0] wr_addr, rd_addr;
  logic [3:0] count;

  logic       d5_gnt0, d5_gnt1, d5_wr_en, d5_wr_sel, d5_rd_en, d5_full, d5_empty;
  logic [2:0] d5_wr_addr, d5_rd_addr;
  logic [2:0] d5_count;

`ifdef FIFO_ARB_ALMOST_EN
  logic almost_full, almost_empty, d5_almost_full, d5_almost_empty;
`endif

  int checks = 0;
  int errors = 0;

  fifo_arb_ctrl #(.DEPTH(8), .ADDR_W(3), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .rd_req(rd_req),
    .gnt0(gnt0), .gnt1(gnt1), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .rd_en(rd_en),
    .count(count), .full(full), .empty(empty)
`ifdef FIFO_ARB_ALMOST_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  fifo_arb_ctrl #(.DEPTH(5), .ADDR_W(3), .CNT_W(3)) dut5 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .rd_req(rd_req),
    .gnt0(d5_gnt0), .gnt1(d5_gnt1), .wr_en(d5_wr_en), .wr_sel(d5_wr_sel),
    .wr_addr(d5_wr_addr), .rd_addr(d5_rd_addr), .rd_en(d5_rd_en),
    .count(d5_count), .full(d5_full), .empty(d5_empty)
`ifdef FIFO_ARB_ALMOST_EN
    , .almost_full(d5_almost_full), .almost_empty(d5_almost_empty)
`endif
  );

  // Falling edge is the active edge; outputs are sampled on the rising edge
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       do_rst;
    logic       r0, r1, rd;
    logic       e_g0, e_g1, e_rden;
    logic [3:0] e_cnt;
    logic [2:0] e_wa, e_ra;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic do_rst, logic r0, logic r1, logic rd,
                              logic g0, logic g1, logic rden,
                              int cnt, int wa, int ra);
    vec_t v;
    v.do_rst = do_rst; v.r0 = r0; v.r1 = r1; v.rd = rd;
    v.e_g0 = g0; v.e_g1 = g1; v.e_rden = rden;
    v.e_cnt = 4'(cnt); v.e_wa = 3'(wa); v.e_ra = 3'(ra);
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic rd);
    @(negedge clk);
    #1;
    req0 = r0; req1 = r1; rd_req = rd;
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; rd_req = 1'b1;

    // Sequence A: three writes from producer 0 only
    vecs.push_back(mk(1, 1,0,0, 1,0,0, 0,0,0));
    vecs.push_back(mk(0, 1,0,0, 1,0,0, 1,1,0));
    vecs.push_back(mk(0, 1,0,0, 1,0,0, 2,2,0));
    vecs.push_back(mk(0, 0,0,0, 0,0,0, 3,3,0));
    // Sequence B: contention alternates grants, then reads mixed with a write
    vecs.push_back(mk(1, 1,1,0, 1,0,0, 0,0,0));
    vecs.push_back(mk(0, 1,1,0, 0,1,0, 1,1,0));
    vecs.push_back(mk(0, 1,1,0, 1,0,0, 2,2,0));
    vecs.push_back(mk(0, 1,1,0, 0,1,0, 3,3,0));
    vecs.push_back(mk(0, 0,0,0, 0,0,0, 4,4,0));
    vecs.push_back(mk(0, 0,0,1, 0,0,1, 4,4,0));
    vecs.push_back(mk(0, 0,1,1, 0,1,1, 3,4,1));
    vecs.push_back(mk(0, 0,0,0, 0,0,0, 3,5,2));
    // Sequence C: write and read on empty, read is blocked
    vecs.push_back(mk(1, 0,1,1, 0,1,0, 0,0,0));
    vecs.push_back(mk(0, 0,0,0, 0,0,0, 1,1,0));

    // Outputs while reset is held, with every request active
    #2;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_gnt0", gnt0, 0);
    checkOutput("rst_gnt1", gnt1, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_rd_en", rd_en, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_rd_addr", rd_addr, 0);

    // Table vectors: each row is checked mid-cycle, before its falling edge
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) doReset();
      applyStimulus(vecs[i].r0, vecs[i].r1, vecs[i].rd);
      @(posedge clk);
      checkOutput($sformatf("v%0d_gnt0", i), gnt0, vecs[i].e_g0);
      checkOutput($sformatf("v%0d_gnt1", i), gnt1, vecs[i].e_g1);
      checkOutput($sformatf("v%0d_wr_en", i), wr_en, vecs[i].e_g0 | vecs[i].e_g1);
      checkOutput($sformatf("v%0d_wr_sel", i), wr_sel, vecs[i].e_g1);
      checkOutput($sformatf("v%0d_rd_en", i), rd_en, vecs[i].e_rden);
      checkOutput($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
      checkOutput($sformatf("v%0d_empty", i), empty, vecs[i].e_cnt == 0);
      checkOutput($sformatf("v%0d_full", i), full, vecs[i].e_cnt == 8);
      checkOutput($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].e_wa);
      checkOutput($sformatf("v%0d_rd_addr", i), rd_addr, vecs[i].e_ra);
    end

    // Full FIFO: write blocked even with concurrent read, granted next cycle
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    checkOutput("full_flag", full, 1);
    checkOutput("full_count", count, 8);
    checkOutput("full_gnt0", gnt0, 0);
    checkOutput("full_wr_en", wr_en, 0);
    checkOutput("full_rd_en", rd_en, 1);
    checkOutput("full_wr_addr", wr_addr, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    checkOutput("after_full_count", count, 7);
    checkOutput("after_full_flag", full, 0);
    checkOutput("after_full_gnt0", gnt0, 1);
    checkOutput("after_full_rd_addr", rd_addr, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    checkOutput("refill_count", count, 8);
    checkOutput("refill_wr_addr", wr_addr, 1);

    // DEPTH=5 instance: interleaved writes and reads wrap both pointers
    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(posedge clk);
      checkOutput($sformatf("d5_w%0d_gnt0", i), d5_gnt0, 1);
      checkOutput($sformatf("d5_w%0d_wr_addr", i), d5_wr_addr, i % 5);
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(posedge clk);
      checkOutput($sformatf("d5_r%0d_rd_en", i), d5_rd_en, 1);
      checkOutput($sformatf("d5_r%0d_rd_addr", i), d5_rd_addr, i % 5);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    checkOutput("d5_final_wr_addr", d5_wr_addr, 2);
    checkOutput("d5_final_rd_addr", d5_rd_addr, 2);
    checkOutput("d5_final_count", d5_count, 0);
    checkOutput("d5_final_empty", d5_empty, 1);

    // Reset mid-stream at count=5 with priority left on producer 1
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    checkOutput("mid_count_pre", count, 5);
    checkOutput("mid_gnt1_pre", gnt1, 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_rst_count", count, 0);
    checkOutput("mid_rst_wr_addr", wr_addr, 0);
    checkOutput("mid_rst_rd_addr", rd_addr, 0);
    checkOutput("mid_rst_gnt0", gnt0, 0);
    checkOutput("mid_rst_gnt1", gnt1, 0);
    checkOutput("mid_rst_wr_en", wr_en, 0);
    checkOutput("mid_rst_rd_en", rd_en, 0);
    checkOutput("mid_rst_empty", empty, 1);
    checkOutput("mid_rst_full", full, 0);
    @(negedge clk);
    #1;
    checkOutput("mid_rst_hold_count", count, 0);
    reset = 1'b0;
    rd_req = 1'b0;
    @(posedge clk);
    checkOutput("post_rst_gnt0", gnt0, 1);
    checkOutput("post_rst_gnt1", gnt1, 0);
    checkOutput("post_rst_rd_en", rd_en, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    checkOutput("post_rst_count", count, 1);
    checkOutput("post_rst_wr_addr", wr_addr, 1);

`ifdef FIFO_ARB_ALMOST_EN
    // Threshold flags with default levels (DEPTH=8: AF=7, AE=1)
    doReset();
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      req0 = 1'b0;
      @(posedge clk);
      checkOutput($sformatf("almost_c%0d_count", i), count, i);
      checkOutput($sformatf("almost_c%0d_ae", i), almost_empty, i <= 1);
      checkOutput($sformatf("almost_c%0d_af", i), almost_full, i >= 7);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_arb_ctrl.md
FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (2..256, any integer).
REQ-002 SHALL have parameter ADDR_W, default 3, pointer width, ceil(log2(DEPTH)).
REQ-003 SHALL have parameter CNT_W, default 4, occupancy width, ceil(log2(DEPTH+1)).
REQ-004 SHALL have port clk  input  1  clock; all state updates on falling edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports req0, req1  input  1 each  write requests from producer 0 and producer 1.
REQ-007 SHALL have port rd_req  input  1  consumer read request.
REQ-008 SHALL have ports gnt0, gnt1  output  1 each  write grant (combinational, one-hot or zero).
REQ-009 SHALL have port wr_en  output  1  storage write strobe; wr_sel  output  1  data mux select (0 = producer 0).
REQ-010 SHALL have ports wr_addr, rd_addr  output  ADDR_W each  storage write and read pointers.
REQ-011 SHALL have port rd_en  output  1  storage read strobe / consumer acknowledge.
REQ-012 SHALL have ports count  output  CNT_W  occupancy; full, empty  output  1 each  flags.

Function
REQ-013 SHALL assert full iff count == DEPTH and empty iff count == 0, combinationally from count.
REQ-014 SHALL grant no writer while full; gnt0/gnt1 low regardless of requests.
REQ-015 SHALL, when not full and exactly one of req0/req1 high, grant that requester.
REQ-016 SHALL, when not full and both requests high, grant the requester holding priority.
REQ-017 SHALL hold a 1-bit priority register; after a write granted to requester N, priority passes to the other requester at the next falling edge; unchanged when no grant.
REQ-018 SHALL drive wr_en = gnt0 | gnt1 and wr_sel = gnt1.
REQ-019 SHALL drive rd_en = rd_req & ~empty.
REQ-020 SHALL increment wr_addr on each wr_en edge, wrapping DEPTH-1 -> 0; likewise rd_addr on rd_en.
REQ-021 SHALL update count: +1 on write only, -1 on read only, unchanged on simultaneous write and read or neither.
REQ-022 SHALL never let count exceed DEPTH or go below 0; full blocks writes even with a concurrent read, empty blocks reads even with a concurrent write.
REQ-023 SHALL have zero-cycle grant latency: a request granted in cycle n is written at the falling edge ending cycle n.

Reset
REQ-024 SHALL, on reset, force wr_addr = 0, rd_addr = 0, count = 0, priority = producer 0, immediately and asynchronously.
REQ-025 SHALL, while reset asserted, hold gnt0, gnt1, wr_en, rd_en low and empty high, full low.
REQ-026 SHALL discard any in-flight operation on reset mid-operation; first post-reset edge behaves as from empty.

Configuration
REQ-027 SHALL, with macro FIFO_ARB_ALMOST_EN defined, add parameters AF_LEVEL (default DEPTH-1) and AE_LEVEL (default 1) and outputs almost_full (count >= AF_LEVEL) and almost_empty (count <= AE_LEVEL), both 1 bit, combinational from count.
REQ-028 SHALL, without FIFO_ARB_ALMOST_EN, omit those parameters and ports entirely; all other behaviour identical.

Verification
REQ-029 SHALL cover: reset, req0=1 for 3 cycles, no read -> gnt0 each cycle, wr_addr 0->3, count=3, empty low.
REQ-030 SHALL cover: req0=req1=1 for 4 cycles from reset -> grants 0,1,0,1, wr_sel 0,1,0,1.
REQ-031 SHALL cover: DEPTH=8, 8 writes then req0=1 with rd_req=1 -> full=1, no grant that cycle, rd_en=1, count 8->7, next cycle granted.
REQ-032 SHALL cover: empty, req1=1 with rd_req=1 -> rd_en=0, gnt1=1, count 0->1.
REQ-033 SHALL cover: DEPTH=5, 7 writes with 7 interleaved reads -> wr_addr and rd_addr wrap 4->0, final value 2.
REQ-034 SHALL cover: reset asserted mid-stream at count=5 -> count, pointers 0 before next edge, priority producer 0; with FIFO_ARB_ALMOST_EN, count=7 -> almost_full=1, count=1 -> almost_empty=1.
